// File: rtl/spi_periph.sv
// SPI target: oversampled sclk/cs/mosi, one DWIDTH-bit word per transfer MSB-first, single-entry TX buffer and RX register.
// Pin edge to action is 3 clk; no backpressure: host strobes always accepted, RX overwrite is flagged via sticky ovr.
module spi_periph #(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DWIDTH-1:0] din,
    input  logic              wr,
    input  logic              rd,
    output logic [DWIDTH-1:0] dout,
    output logic              done,
    output logic              rx_valid,
    output logic              tx_full,
    output logic              ovr,
    output logic              busy
);

    localparam int CW = (DWIDTH > 2) ? $clog2(DWIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [2:0]        sclk_s;
    logic [2:0]        cs_s;
    logic [1:0]        mosi_s;
    logic              sclk_rise, sclk_fall, cs_fall;

    state_t            state, state_n;
    logic [CW-1:0]     bitcnt, bitcnt_n;
    logic [DWIDTH-1:0] rx_sr, rx_sr_n, rx_shift;
    logic [DWIDTH-1:0] tx_sr, tx_sr_n;
    logic [DWIDTH-1:0] tx_buf, tx_buf_n;
    logic [DWIDTH-1:0] dout_n;
    logic              reload, reload_n;
    logic              miso_n, done_n, rx_valid_n, tx_full_n, ovr_n;
    logic              load, complete;

    // bit 0 = first sync flop, bit 1 = synchronized value, bit 2 = edge-detect history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_s <= 3'b000;
            cs_s   <= 3'b111;
            mosi_s <= 2'b00;
        end else begin
            sclk_s <= {sclk_s[1:0], sclk};
            cs_s   <= {cs_s[1:0], cs};
            mosi_s <= {mosi_s[0], mosi};
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign cs_fall   = ~cs_s[1] & cs_s[2];
    assign busy      = ~cs_s[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bitcnt   <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            tx_buf   <= '0;
            reload   <= 1'b0;
            miso     <= 1'b0;
            dout     <= '0;
            done     <= 1'b0;
            rx_valid <= 1'b0;
            tx_full  <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            state    <= state_n;
            bitcnt   <= bitcnt_n;
            rx_sr    <= rx_sr_n;
            tx_sr    <= tx_sr_n;
            tx_buf   <= tx_buf_n;
            reload   <= reload_n;
            miso     <= miso_n;
            dout     <= dout_n;
            done     <= done_n;
            rx_valid <= rx_valid_n;
            tx_full  <= tx_full_n;
            ovr      <= ovr_n;
        end
    end

    always_comb begin
        state_n    = state;
        bitcnt_n   = bitcnt;
        rx_sr_n    = rx_sr;
        tx_sr_n    = tx_sr;
        tx_buf_n   = tx_buf;
        reload_n   = reload;
        miso_n     = miso;
        dout_n     = dout;
        done_n     = 1'b0;
        rx_valid_n = rx_valid;
        tx_full_n  = tx_full;
        ovr_n      = ovr;
        load       = 1'b0;
        complete   = 1'b0;
        rx_shift   = {rx_sr[DWIDTH-2:0], mosi_s[1]};

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n  = SHIFT;
                    load     = 1'b1;
                    bitcnt_n = '0;
                    reload_n = 1'b0;
                end
            end
            SHIFT: begin
                // cs deassertion takes priority over any coincident sclk edge
                if (cs_s[1]) begin
                    state_n  = IDLE;
                    miso_n   = 1'b0;
                    bitcnt_n = '0;
                    reload_n = 1'b0;
                end else if (sclk_rise) begin
                    rx_sr_n = rx_shift;
                    if (bitcnt == LAST) begin
                        complete = 1'b1;
                        bitcnt_n = '0;
                        reload_n = 1'b1;
                    end else begin
                        bitcnt_n = bitcnt + CW'(1);
                    end
                end else if (sclk_fall) begin
                    if (reload) begin
                        load     = 1'b1;
                        reload_n = 1'b0;
                    end else begin
                        tx_sr_n = {tx_sr[DWIDTH-2:0], 1'b0};
                        miso_n  = tx_sr[DWIDTH-2];
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // shifter takes the current buffer; a same-cycle wr lands in the buffer afterwards
        if (load) begin
            tx_sr_n   = tx_full ? tx_buf : '0;
            miso_n    = tx_full & tx_buf[DWIDTH-1];
            tx_full_n = 1'b0;
        end
        if (wr) begin
            tx_buf_n  = din;
            tx_full_n = 1'b1;
        end

        if (complete) begin
            dout_n     = rx_shift;
            done_n     = 1'b1;
            rx_valid_n = 1'b1;
            ovr_n      = rd ? 1'b0 : (ovr | rx_valid);
        end else if (rd) begin
            rx_valid_n = 1'b0;
            ovr_n      = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_periph.sv
// Directed bench for spi_periph: bit-banged SPI controller plus host strobes, hand-computed expectations.
module tb_spi_periph;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst, sclk, cs, mosi, wr, rd_man, rd_auto, auto_rd;
    logic       rd;
    logic [7:0] din;
    logic       miso, done, rx_valid, tx_full, ovr, busy;
    logic [7:0] dout;

    int         pass_cnt = 0;
    int         tot_cnt  = 0;
    int         done_cnt = 0;
    logic [7:0] cap[$];

    assign rd = rd_man | rd_auto;

    spi_periph #(.DWIDTH(8)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .din(din), .wr(wr), .rd(rd), .dout(dout), .done(done),
        .rx_valid(rx_valid), .tx_full(tx_full), .ovr(ovr), .busy(busy)
    );

    always #5 clk = ~clk;

    initial rd_auto = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            cap.push_back(dout);
        end
        rd_auto = auto_rd && done;
    end

    task automatic host_wr(input logic [7:0] d);
        din = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic host_rd();
        rd_man = 1'b1;
        @(negedge clk);
        rd_man = 1'b0;
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // mode 1: rd lands on the completion cycle of bit 7; mode 2: wr 0x7E while bit 4 is high
    task automatic spi_bits(input logic [7:0] m, input int n, input int mode, output logic [7:0] s);
        s = 8'h00;
        for (int k = 0; k < n; k++) begin
            mosi = m[7-k];
            repeat (HALF) @(negedge clk);
            s[7-k] = miso;
            sclk = 1'b1;
            if (mode == 1 && k == 7) begin
                repeat (2) @(negedge clk);
                rd_man = 1'b1;
                @(negedge clk);
                rd_man = 1'b0;
                repeat (HALF-3) @(negedge clk);
            end else if (mode == 2 && k == 4) begin
                repeat (2) @(negedge clk);
                din = 8'h7E; wr = 1'b1;
                @(negedge clk);
                wr = 1'b0;
                repeat (HALF-3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] s;
        rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wr = 1'b0; rd_man = 1'b0; din = 8'h00; auto_rd = 1'b0;
        repeat (3) @(negedge clk);
        tot_cnt++;
        if ({miso, dout, done, rx_valid, tx_full, ovr, busy} !== 14'h0)
            $display("FAIL reset_outputs: got %h want 0", {miso, dout, done, rx_valid, tx_full, ovr, busy});
        else pass_cnt++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        host_wr(8'hFF);
        cs_low();
        host_wr(8'h12);
        spi_bits(8'hA0, 3, 0, s);
        tot_cnt++;
        if (miso !== 1'b1 || tx_full !== 1'b1 || busy !== 1'b1)
            $display("FAIL reset_pre: miso=%b tx_full=%b busy=%b want 1 1 1", miso, tx_full, busy);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        tot_cnt++;
        if ({miso, dout, done, rx_valid, tx_full, ovr, busy} !== 14'h0)
            $display("FAIL reset_midxfer: got %h want 0", {miso, dout, done, rx_valid, tx_full, ovr, busy});
        else pass_cnt++;
        @(negedge clk);
        cs = 1'b1; sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        host_wr(8'h5C);
        cs_low();
        spi_bits(8'hE7, 8, 0, s);
        cs_high();
        tot_cnt++;
        if (s !== 8'h5C || dout !== 8'hE7)
            $display("FAIL reset_after: miso word %h dout %h want 5c e7", s, dout);
        else pass_cnt++;
    endtask

    task automatic test_single();
        logic [7:0] s;
        int d0;
        host_rd();
        host_wr(8'hA5);
        tot_cnt++;
        if (tx_full !== 1'b1) $display("FAIL single_tx_full_set: got %b want 1", tx_full);
        else pass_cnt++;
        d0 = done_cnt;
        cs_low();
        tot_cnt++;
        if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy);
        else pass_cnt++;
        spi_bits(8'h3C, 8, 0, s);
        cs_high();
        tot_cnt++;
        if (s !== 8'hA5) $display("FAIL single_miso: got %h want a5", s);
        else pass_cnt++;
        tot_cnt++;
        if (done_cnt - d0 !== 1) $display("FAIL single_done_cycles: got %0d want 1", done_cnt - d0);
        else pass_cnt++;
        tot_cnt++;
        if (dout !== 8'h3C || rx_valid !== 1'b1 || tx_full !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_flags: dout=%h rxv=%b txf=%b busy=%b want 3c 1 0 0", dout, rx_valid, tx_full, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] s1, s2;
        int c0;
        host_rd();
        host_wr(8'h81);
        auto_rd = 1'b1;
        c0 = cap.size();
        cs_low();
        spi_bits(8'h11, 8, 2, s1);
        spi_bits(8'h22, 8, 0, s2);
        cs_high();
        auto_rd = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if (s1 !== 8'h81 || s2 !== 8'h7E) $display("FAIL b2b_miso: got %h %h want 81 7e", s1, s2);
        else pass_cnt++;
        tot_cnt++;
        if (cap.size() - c0 !== 2) $display("FAIL b2b_done_count: got %0d want 2", cap.size() - c0);
        else if (cap[c0] !== 8'h11 || cap[c0+1] !== 8'h22)
            $display("FAIL b2b_dout: got %h %h want 11 22", cap[c0], cap[c0+1]);
        else pass_cnt++;
        tot_cnt++;
        if (ovr !== 1'b0 || rx_valid !== 1'b0) $display("FAIL b2b_flags: ovr=%b rxv=%b want 0 0", ovr, rx_valid);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        logic [7:0] s;
        int d0;
        d0 = done_cnt;
        cs_low();
        spi_bits(8'h5A, 8, 0, s);
        tot_cnt++;
        if (ovr !== 1'b0 || rx_valid !== 1'b1) $display("FAIL ovr_first: ovr=%b rxv=%b want 0 1", ovr, rx_valid);
        else pass_cnt++;
        spi_bits(8'hC3, 8, 0, s);
        cs_high();
        tot_cnt++;
        if (done_cnt - d0 !== 2 || ovr !== 1'b1 || dout !== 8'hC3)
            $display("FAIL ovr_set: dones=%0d ovr=%b dout=%h want 2 1 c3", done_cnt - d0, ovr, dout);
        else pass_cnt++;
        host_rd();
        tot_cnt++;
        if (rx_valid !== 1'b0 || ovr !== 1'b0) $display("FAIL ovr_clear: rxv=%b ovr=%b want 0 0", rx_valid, ovr);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [7:0] s;
        int d0;
        host_wr(8'hFF);
        d0 = done_cnt;
        cs_low();
        spi_bits(8'hAA, 5, 0, s);
        tot_cnt++;
        if (miso !== 1'b1) $display("FAIL abort_pre_miso: got %b want 1", miso);
        else pass_cnt++;
        cs_high();
        tot_cnt++;
        if (done_cnt !== d0 || dout !== 8'hC3 || miso !== 1'b0 || rx_valid !== 1'b0)
            $display("FAIL abort_state: dones=%0d dout=%h miso=%b rxv=%b want %0d c3 0 0", done_cnt, dout, miso, rx_valid, d0);
        else pass_cnt++;
        cs_low();
        spi_bits(8'h96, 8, 0, s);
        cs_high();
        tot_cnt++;
        if (dout !== 8'h96 || done_cnt - d0 !== 1) $display("FAIL abort_next: dout=%h dones=%0d want 96 1", dout, done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_empty_tx();
        logic [7:0] s;
        host_rd();
        cs_low();
        spi_bits(8'h42, 8, 0, s);
        cs_high();
        tot_cnt++;
        if (s !== 8'h00 || dout !== 8'h42) $display("FAIL empty_tx: miso word %h dout %h want 00 42", s, dout);
        else pass_cnt++;
    endtask

    task automatic test_collisions();
        logic [7:0] s;
        host_rd();
        host_wr(8'h33);
        cs = 1'b0;
        repeat (2) @(negedge clk);
        din = 8'hCC; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        repeat (3) @(negedge clk);
        tot_cnt++;
        if (tx_full !== 1'b1) $display("FAIL coll_wr_tx_full: got %b want 1", tx_full);
        else pass_cnt++;
        spi_bits(8'h01, 8, 0, s);
        tot_cnt++;
        if (s !== 8'h33 || tx_full !== 1'b0) $display("FAIL coll_wr_word: miso word %h txf %b want 33 0", s, tx_full);
        else pass_cnt++;
        spi_bits(8'h77, 8, 1, s);
        cs_high();
        tot_cnt++;
        if (s !== 8'hCC) $display("FAIL coll_second_word: got %h want cc", s);
        else pass_cnt++;
        tot_cnt++;
        if (rx_valid !== 1'b1 || ovr !== 1'b0 || dout !== 8'h77)
            $display("FAIL coll_rd_done: rxv=%b ovr=%b dout=%h want 1 0 77", rx_valid, ovr, dout);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_empty_tx();
        test_collisions();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
